// File: rtl/axis_pkg.sv
// ============================================================================
// Module  : axis_pkg
// Brief   : Shared types and constants for the AXI-Stream pattern source/sink.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_pkg;

    localparam int              THR_W    = 16;
    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [THR_W-1:0] THR_POLY = 16'hB400;

    typedef enum logic {
        PAT_CNT = 1'b0,
        PAT_ALT = 1'b1
    } pat_mode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } src_state_e;

endpackage

`default_nettype wire

// File: rtl/axis_lfsr_throttle.sv
// ============================================================================
// Module  : axis_lfsr_throttle
// Brief   : Free-running 16-bit Galois LFSR with a probability compare on the
//           low byte; o_ok is high on roughly PROB/256 of all cycles.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_lfsr_throttle
    import axis_pkg::*;
#(
    parameter logic [THR_W-1:0] SEED = 16'hACE1,
    parameter int               PROB = 256
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_ok
);

    localparam logic [8:0] c_PROB = 9'(PROB);

    logic [THR_W-1:0] r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[THR_W-1:1]} ^ (r_lfsr[0] ? THR_POLY : '0);
        end
    end

    // Nine-bit compare so PROB=256 is always true
    assign o_ok = ({1'b0, r_lfsr[7:0]} < c_PROB);

endmodule

`default_nettype wire

// File: rtl/axis_pattern_source.sv
// ============================================================================
// Module  : axis_pattern_source
// Brief   : AXI-Stream packet generator (counter / alternating-inversion
//           pattern) with LFSR-throttled valid. Define AXIS_SRC_STALL_CNT_EN
//           to add the o_stall_cnt back-pressure counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_pattern_source
    import axis_pkg::*;
#(
    parameter int               WORD_W     = 8,
    parameter int               BUS_W      = 32,
    parameter int               LEN_W      = 8,
    parameter int               PROB_VALID = 256,
    parameter logic [THR_W-1:0] THR_SEED   = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_start,
    input  logic [LEN_W-1:0]          i_len,
    input  logic                      i_mode,
    input  logic [WORD_W-1:0]         i_seed,
    output logic                      o_m_valid,
    input  logic                      i_m_ready,
    output logic [BUS_W-1:0]          o_m_data,
    output logic [BUS_W/WORD_W-1:0]   o_m_keep,
    output logic                      o_m_last,
    output logic                      o_busy,
    output logic                      o_done
`ifdef AXIS_SRC_STALL_CNT_EN
    ,
    output logic [15:0]               o_stall_cnt
`endif
);

    localparam int   c_WPB     = BUS_W / WORD_W;
    localparam logic c_WPB_ODD = 1'(c_WPB % 2);

    src_state_e          r_state, w_state;
    pat_mode_e           r_mode, w_mode;
    logic [LEN_W-1:0]    r_rem, w_rem;
    logic [WORD_W-1:0]   r_base, w_base;
    logic                r_odd, w_odd;
    logic                r_valid, w_valid;
    logic [BUS_W-1:0]    r_data, w_data;
    logic [c_WPB-1:0]    r_keep, w_keep;
    logic                r_last, w_last;
    logic                r_busy, w_busy;
    logic                r_done, w_done;
    logic                w_load;
    logic                w_fire;
    logic                w_thr_ok;
    logic [WORD_W-1:0]   w_lane;
    logic                w_inv;

    axis_lfsr_throttle #(
        .SEED (THR_SEED),
        .PROB (PROB_VALID)
    ) u_thr (
        .clk   (clk),
        .rst_n (rst_n),
        .o_ok  (w_thr_ok)
    );

    assign w_fire = r_valid & i_m_ready;

    // r_rem/r_base/r_odd describe the next beat still to be loaded; on an
    // accepted start they are fed straight from the inputs so the first beat
    // can appear the cycle after start.
    always_comb begin
        w_state = r_state;
        w_mode  = r_mode;
        w_rem   = r_rem;
        w_base  = r_base;
        w_odd   = r_odd;
        w_valid = r_valid;
        w_data  = r_data;
        w_keep  = r_keep;
        w_last  = r_last;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_load  = 1'b0;
        w_lane  = '0;
        w_inv   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_len != '0) begin
                        w_state = S_RUN;
                        w_busy  = 1'b1;
                        w_mode  = pat_mode_e'(i_mode);
                        w_rem   = i_len;
                        w_base  = i_seed;
                        w_odd   = 1'b0;
                        w_load  = w_thr_ok;
                    end else begin
                        w_done  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (!r_valid || w_fire) begin
                    w_valid = 1'b0;
                    if (r_valid && r_last) begin
                        w_state = S_IDLE;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                    end else begin
                        w_load  = w_thr_ok && (r_rem != '0);
                    end
                end
            end
        endcase

        if (w_load) begin
            w_valid = 1'b1;
            w_last  = (int'(w_rem) <= c_WPB);
            for (int j = 0; j < c_WPB; j++) begin
                w_lane = w_base + WORD_W'(j);
                w_inv  = (w_mode == PAT_ALT) && (w_odd ^ j[0]);
                if (int'(w_rem) > j) begin
                    w_data[j*WORD_W +: WORD_W] = w_inv ? ~w_lane : w_lane;
                    w_keep[j]                  = 1'b1;
                end else begin
                    w_data[j*WORD_W +: WORD_W] = '0;
                    w_keep[j]                  = 1'b0;
                end
            end
            w_rem  = (int'(w_rem) > c_WPB) ? w_rem - LEN_W'(c_WPB) : '0;
            w_base = w_base + WORD_W'(c_WPB);
            w_odd  = w_odd ^ c_WPB_ODD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mode  <= PAT_CNT;
            r_rem   <= '0;
            r_base  <= '0;
            r_odd   <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_mode  <= w_mode;
            r_rem   <= w_rem;
            r_base  <= w_base;
            r_odd   <= w_odd;
            r_valid <= w_valid;
            r_data  <= w_data;
            r_keep  <= w_keep;
            r_last  <= w_last;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    assign o_m_valid = r_valid;
    assign o_m_data  = r_data;
    assign o_m_keep  = r_keep;
    assign o_m_last  = r_last;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

`ifdef AXIS_SRC_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_IDLE) && i_start) begin
            r_stall_cnt <= '0;
        end else if (r_valid && !i_m_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_pattern_source.sv
// ============================================================================
// Module  : tb_axis_pattern_source
// Brief   : Self-checking bench: a 32-bit/unthrottled instance and an
//           8-bit/throttled instance checked against a queue scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axis_pattern_source;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_a_t;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } word_b_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_start, a_mode, a_ready;
    logic [7:0]  a_len, a_seed;
    logic        a_valid, a_last, a_busy, a_done;
    logic [31:0] a_data;
    logic [3:0]  a_keep;

    logic        b_start, b_mode, b_ready;
    logic [7:0]  b_len, b_seed;
    logic        b_valid, b_last, b_busy, b_done;
    logic [7:0]  b_data;
    logic [0:0]  b_keep;
`ifdef AXIS_SRC_STALL_CNT_EN
    logic [15:0] a_stall, b_stall;
`endif

    int checks = 0;
    int errors = 0;

    beat_a_t qa[$];
    word_b_t qb[$];

    axis_pattern_source #(
        .WORD_W(8), .BUS_W(32), .LEN_W(8), .PROB_VALID(256), .THR_SEED(16'hACE1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_start(a_start), .i_len(a_len), .i_mode(a_mode),
        .i_seed(a_seed), .o_m_valid(a_valid), .i_m_ready(a_ready), .o_m_data(a_data),
        .o_m_keep(a_keep), .o_m_last(a_last), .o_busy(a_busy), .o_done(a_done)
`ifdef AXIS_SRC_STALL_CNT_EN
        , .o_stall_cnt(a_stall)
`endif
    );

    axis_pattern_source #(
        .WORD_W(8), .BUS_W(8), .LEN_W(8), .PROB_VALID(51), .THR_SEED(16'hACE1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_start(b_start), .i_len(b_len), .i_mode(b_mode),
        .i_seed(b_seed), .o_m_valid(b_valid), .i_m_ready(b_ready), .o_m_data(b_data),
        .o_m_keep(b_keep), .o_m_last(b_last), .o_busy(b_busy), .o_done(b_done)
`ifdef AXIS_SRC_STALL_CNT_EN
        , .o_stall_cnt(b_stall)
`endif
    );

    function automatic logic [7:0] pat(input logic [7:0] s, input int k, input logic m);
        logic [7:0] v;
        v = s + 8'(k);
        return (m && k[0]) ? ~v : v;
    endfunction

    task automatic push_a(input logic [7:0] s, input int n, input logic m);
        beat_a_t bt;
        for (int b = 0; b * 4 < n; b++) begin
            bt = '0;
            for (int j = 0; j < 4; j++) begin
                if (b * 4 + j < n) begin
                    bt.d[j*8 +: 8] = pat(s, b * 4 + j, m);
                    bt.k[j]        = 1'b1;
                end
            end
            bt.l = (b * 4 + 4 >= n);
            qa.push_back(bt);
        end
    endtask

    task automatic push_b(input logic [7:0] s, input int n, input logic m);
        for (int k = 0; k < n; k++) qb.push_back({pat(s, k, m), (k == n - 1)});
    endtask

    task automatic test_reset();
        checks++;
        if ({a_valid, a_data, a_keep, a_last, a_busy, a_done} !== '0) begin
            errors++;
            $display("FAIL reset_a: got v=%b d=%h k=%h l=%b busy=%b done=%b, required all 0",
                     a_valid, a_data, a_keep, a_last, a_busy, a_done);
        end
        checks++;
        if ({b_valid, b_data, b_keep, b_last, b_busy, b_done} !== '0) begin
            errors++;
            $display("FAIL reset_b: got v=%b d=%h k=%h l=%b busy=%b done=%b, required all 0",
                     b_valid, b_data, b_keep, b_last, b_busy, b_done);
        end
`ifdef AXIS_SRC_STALL_CNT_EN
        checks++;
        if (a_stall !== 16'd0) begin
            errors++;
            $display("FAIL reset_stall: got %h, required 0000", a_stall);
        end
`endif
    endtask

    // Three beats of len=10, then a restart held high across the final handshake
    task automatic test_basic();
        beat_a_t exp;
        qa.delete();
        a_ready = 1'b1; a_start = 1'b1; a_len = 8'd10; a_seed = 8'h10; a_mode = 1'b0;
        push_a(8'h10, 10, 1'b0);
        @(negedge clk);
        a_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (a_valid !== 1'b1 || a_busy !== 1'b1) begin
                errors++;
                $display("FAIL basic_valid beat %0d: got valid=%b busy=%b, required 1 1", i, a_valid, a_busy);
            end
            if (i == 2) begin
                a_start = 1'b1; a_len = 8'd2; a_seed = 8'hA0; a_mode = 1'b1;
            end
            exp = qa.pop_front();
            checks++;
            if ({a_data, a_keep, a_last} !== exp) begin
                errors++;
                $display("FAIL basic_beat %0d: got d=%h k=%h l=%b, required d=%h k=%h l=%b",
                         i, a_data, a_keep, a_last, exp.d, exp.k, exp.l);
            end
            @(negedge clk);
        end
        checks++;
        if (a_done !== 1'b1 || a_busy !== 1'b0 || a_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: got done=%b busy=%b valid=%b, required 1 0 0", a_done, a_busy, a_valid);
        end
        push_a(8'hA0, 2, 1'b1);
        @(negedge clk);
        a_start = 1'b0;
        exp = qa.pop_front();
        checks++;
        if ({a_valid, a_busy, a_data, a_keep, a_last} !== {2'b11, exp}) begin
            errors++;
            $display("FAIL restart_beat: got v=%b busy=%b d=%h k=%h l=%b, required v=1 busy=1 d=%h k=%h l=%b",
                     a_valid, a_busy, a_data, a_keep, a_last, exp.d, exp.k, exp.l);
        end
        @(negedge clk);
        checks++;
        if (a_done !== 1'b1 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_done: got done=%b busy=%b, required 1 0", a_done, a_busy);
        end
        @(negedge clk);
        checks++;
        if (a_done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got done=%b, required 0", a_done);
        end
    endtask

    task automatic test_hold();
        beat_a_t exp;
        bit      got_done;
        qa.delete();
        a_ready = 1'b0; a_start = 1'b1; a_len = 8'd10; a_seed = 8'h10; a_mode = 1'b0;
        push_a(8'h10, 10, 1'b0);
        @(negedge clk);
        a_start = 1'b0;
        exp = qa[0];
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({a_valid, a_data, a_keep, a_last} !== {1'b1, exp}) begin
                errors++;
                $display("FAIL hold_stable cycle %0d: got v=%b d=%h k=%h l=%b, required v=1 d=%h k=%h l=%b",
                         i, a_valid, a_data, a_keep, a_last, exp.d, exp.k, exp.l);
            end
            @(negedge clk);
        end
        a_ready  = 1'b1;
        got_done = 1'b0;
        for (int cyc = 0; cyc < 20 && !got_done; cyc++) begin
            if (a_done) got_done = 1'b1;
            if (a_valid && a_ready) begin
                exp = qa.pop_front();
                checks++;
                if ({a_data, a_keep, a_last} !== exp) begin
                    errors++;
                    $display("FAIL hold_drain: got d=%h k=%h l=%b, required d=%h k=%h l=%b",
                             a_data, a_keep, a_last, exp.d, exp.k, exp.l);
                end
            end
            if (!got_done) @(negedge clk);
        end
        checks++;
        if (!got_done || qa.size() != 0) begin
            errors++;
            $display("FAIL hold_complete: got done=%b beats_left=%0d, required 1 0", got_done, qa.size());
        end
    endtask

    task automatic test_len0();
        @(negedge clk);
        a_start = 1'b1; a_len = 8'd0; a_seed = 8'h33; a_mode = 1'b0;
        @(negedge clk);
        a_start = 1'b0;
        checks++;
        if (a_done !== 1'b1 || a_busy !== 1'b0 || a_valid !== 1'b0) begin
            errors++;
            $display("FAIL len0_done: got done=%b busy=%b valid=%b, required 1 0 0", a_done, a_busy, a_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (a_done !== 1'b0 || a_busy !== 1'b0 || a_valid !== 1'b0) begin
                errors++;
                $display("FAIL len0_quiet %0d: got done=%b busy=%b valid=%b, required 0 0 0",
                         i, a_done, a_busy, a_valid);
            end
        end
    endtask

    task automatic test_random();
        word_b_t    exp;
        bit         got_done, hold;
        logic [7:0] prev_d;
        logic       prev_l;
        qb.delete();
        push_b(8'hF0, 100, 1'b0);
        b_ready = 1'b0; b_start = 1'b1; b_len = 8'd100; b_seed = 8'hF0; b_mode = 1'b0;
        got_done = 1'b0; hold = 1'b0; prev_d = '0; prev_l = 1'b0;
        @(negedge clk);
        b_start = 1'b0;
        for (int cyc = 0; cyc < 8000 && !got_done; cyc++) begin
            if (hold) begin
                checks++;
                if (b_valid !== 1'b1 || b_data !== prev_d || b_last !== prev_l) begin
                    errors++;
                    $display("FAIL random_hold: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                             b_valid, b_data, b_last, prev_d, prev_l);
                end
            end
            if (b_done) got_done = 1'b1;
            b_ready = ($urandom_range(0, 99) < 20);
            if (b_valid && b_ready) begin
                exp = qb.pop_front();
                checks++;
                if (b_data !== exp.d || b_last !== exp.l || b_keep !== 1'b1) begin
                    errors++;
                    $display("FAIL random_word: got d=%h l=%b k=%b, required d=%h l=%b k=1",
                             b_data, b_last, b_keep, exp.d, exp.l);
                end
            end
            hold = b_valid && !b_ready; prev_d = b_data; prev_l = b_last;
            @(negedge clk);
        end
        checks++;
        if (!got_done || qb.size() != 0) begin
            errors++;
            $display("FAIL random_complete: got done=%b words_left=%0d, required 1 0", got_done, qb.size());
        end
    endtask

    task automatic test_reset_mid();
        word_b_t exp;
        int      hs;
        bit      got_done;
        qb.delete();
        b_ready = 1'b1; b_start = 1'b1; b_len = 8'd8; b_seed = 8'h30; b_mode = 1'b0;
        hs = 0;
        @(negedge clk);
        b_start = 1'b0;
        for (int cyc = 0; cyc < 500 && hs < 2; cyc++) begin
            if (b_valid && b_ready) hs++;
            @(negedge clk);
        end
        checks++;
        if (hs != 2) begin
            errors++;
            $display("FAIL resetmid_progress: got %0d handshakes, required 2", hs);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({b_valid, b_data, b_keep, b_last, b_busy, b_done} !== '0) begin
            errors++;
            $display("FAIL resetmid_clear: got v=%b d=%h k=%b l=%b busy=%b done=%b, required all 0",
                     b_valid, b_data, b_keep, b_last, b_busy, b_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (b_done !== 1'b0 || b_valid !== 1'b0 || b_busy !== 1'b0) begin
                errors++;
                $display("FAIL resetmid_quiet %0d: got done=%b valid=%b busy=%b, required 0 0 0",
                         i, b_done, b_valid, b_busy);
            end
        end
        push_b(8'h55, 4, 1'b0);
        b_start = 1'b1; b_len = 8'd4; b_seed = 8'h55; b_mode = 1'b0;
        got_done = 1'b0;
        @(negedge clk);
        b_start = 1'b0;
        for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
            if (b_done) got_done = 1'b1;
            if (b_valid && b_ready) begin
                exp = qb.pop_front();
                checks++;
                if (b_data !== exp.d || b_last !== exp.l) begin
                    errors++;
                    $display("FAIL resetmid_word: got d=%h l=%b, required d=%h l=%b", b_data, b_last, exp.d, exp.l);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (!got_done || qb.size() != 0) begin
            errors++;
            $display("FAIL resetmid_complete: got done=%b words_left=%0d, required 1 0", got_done, qb.size());
        end
    endtask

    task automatic test_alt();
        word_b_t exp;
        bit      got_done;
        int      stall_left;
        qb.delete();
        push_b(8'h00, 4, 1'b1);
        stall_left = 5;
`ifdef AXIS_SRC_STALL_CNT_EN
        b_ready = 1'b0;
`else
        b_ready = 1'b1;
`endif
        b_start = 1'b1; b_len = 8'd4; b_seed = 8'h00; b_mode = 1'b1;
        got_done = 1'b0;
        @(negedge clk);
        b_start = 1'b0;
        for (int cyc = 0; cyc < 500 && !got_done; cyc++) begin
            if (b_done) got_done = 1'b1;
            if (b_valid && !b_ready) begin
                if (stall_left == 0) b_ready = 1'b1;
                else stall_left--;
            end
            if (b_valid && b_ready) begin
                exp = qb.pop_front();
                checks++;
                if (b_data !== exp.d || b_last !== exp.l) begin
                    errors++;
                    $display("FAIL alt_word: got d=%h l=%b, required d=%h l=%b", b_data, b_last, exp.d, exp.l);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (!got_done || qb.size() != 0) begin
            errors++;
            $display("FAIL alt_complete: got done=%b words_left=%0d, required 1 0", got_done, qb.size());
        end
`ifdef AXIS_SRC_STALL_CNT_EN
        checks++;
        if (b_stall !== 16'd5) begin
            errors++;
            $display("FAIL alt_stall_cnt: got %0d, required 5", b_stall);
        end
`endif
    endtask

    initial begin
        rst_n   = 1'b0;
        a_start = 1'b0; a_len = '0; a_seed = '0; a_mode = 1'b0; a_ready = 1'b0;
        b_start = 1'b0; b_len = '0; b_seed = '0; b_mode = 1'b0; b_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_basic();
        test_hold();
        test_len0();
        test_random();
        test_reset_mid();
        test_alt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axis_pattern_source.md
Name: axis_pattern_source

Overview:
- Synthesizable, parametrised AXI-Stream packet generator for on-chip self-test of stream datapaths such as the UART-MVM input path.
- Emits one packet per `start`, `len` words long, packed several words per beat, LSB-lane first.
- `m_valid` is throttled pseudo-randomly by an internal LFSR.
- Drives `m_keep`/`m_last`, so non-multiple-of-bus packet lengths are supported.

Parameters:
- WORD_W, 8, word width in bits
- BUS_W, 32, beat width in bits; must be a multiple of WORD_W; WPB = BUS_W/WORD_W
- LEN_W, 8, width of the packet-length port (in words)
- PROB_VALID, 256, valid-assert probability out of 256; legal range 1..256; 256 means never throttle
- THR_SEED, 16'hACE1, reset value of the throttle LFSR; must be nonzero

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a packet; ignored while busy
- len  in  LEN_W  packet length in words, captured on accepted start
- mode  in  1  0 = counter pattern, 1 = alternating-inversion pattern; captured on start
- seed  in  WORD_W  first pattern value, captured on start
- m_valid  out  1  AXIS valid
- m_ready  in  1  AXIS ready
- m_data  out  WPB x WORD_W  packed, lane 0 = earliest word
- m_keep  out  WPB  per-lane valid word
- m_last  out  1  final beat of the packet
- busy  out  1  high from the cycle after an accepted start until the final handshake
- done  out  1  one-cycle pulse, cycle after packet completion

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; m_valid, m_data, m_keep, m_last, busy, done all 0; throttle LFSR=THR_SEED.
- Every output is a flop.
- FSM states: IDLE, RUN.
- IDLE, start=1, len!=0:
  - capture len/mode/seed, word index k=0, go to RUN, busy=1 next cycle.
- IDLE, start=1, len==0:
  - stay in IDLE, done=1 next cycle, no beat emitted.
- Pattern for word k:
  - mode 0: seed+k mod 2^WORD_W.
  - mode 1: k even → seed+k; k odd → ~(seed+k).
- Beat contents:
  - Beat b carries words k = b·WPB .. b·WPB+WPB-1.
  - Lanes with k >= len: keep=0, data=0.
  - Beat count = ceil(len/WPB).
  - m_last=1 only on the final beat.
- Throttle LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle, regardless of state.
  - throttle_ok = (lfsr[7:0] < PROB_VALID).
- Valid rules:
  - Once m_valid=1, m_valid, m_data, m_keep and m_last are held stable until m_valid&m_ready. This is mandatory AXIS compliance.
  - When not holding, m_valid is registered to (RUN and beats remaining and throttle_ok).
  - First possible m_valid is the cycle after start.
  - Back-to-back beats are allowed: a handshake and the next valid may occur on consecutive cycles.
- Final handshake (m_last&m_valid&m_ready):
  - next cycle: m_valid=0, busy=0, done=1, FSM=IDLE.
  - start in that same cycle is ignored.
  - A new start is accepted the following cycle.
- Counter wrap: the pattern wraps modulo 2^WORD_W. len is unsigned; its maximum is 2^LEN_W-1.
- Reset mid-packet: outputs clear immediately (async); the packet is abandoned; no done pulse.

Optional Feature:
- Macro AXIS_SRC_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt (16 bits).
  - Counts cycles with m_valid&!m_ready during the current packet.
  - Saturates at 16'hFFFF.
  - Cleared on accepted start and on reset.
  - Holds its value after done.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package axis_pkg:
  - THR_W=16.
  - THR_POLY constant.
  - typedef enum logic {PAT_CNT, PAT_ALT} pat_mode_e.
  - typedef enum logic {S_IDLE, S_RUN} src_state_e.
- Sub-module axis_lfsr_throttle:
  - parameters SEED, PROB.
  - ports clk, rst_n, ok.
  - Free-running LFSR plus compare; reused by a future axis_pattern_sink for ready throttling.

Test Plan:
1. BUS_W=32, PROB_VALID=256, m_ready=1, len=10, seed=8'h10, mode=0, start at cycle 0 → three beats:
   - cycle 1: data 13121110, keep F.
   - cycle 2: data 17161514, keep F.
   - cycle 3: data 00001918, keep 3, last=1.
   - cycle 4: done=1, busy=0.
2. Same config, m_ready=0 for 20 cycles after first valid → m_valid stays 1 and data/keep/last are bit-stable all 20 cycles; the beat transfers when m_ready rises.
3. len=0 start → done=1 next cycle; m_valid never asserts; busy stays 0.
4. BUS_W=8, PROB_VALID=51, m_ready random 20%, len=100, seed=8'hF0, mode=0 → scoreboard receives exactly F0..FF, 00..53 in order; m_last only on word 100; no valid drops without a handshake.
5. rst_n pulsed low mid-packet at beat 2 → all outputs 0 within the reset cycle; no done; a new start (len=4) then produces a correct full packet.
6. BUS_W=8, mode=1, seed=8'h00, len=4 → data 00, FE, 02, FC, last on FC. If AXIS_SRC_STALL_CNT_EN is defined and m_ready is held low 5 cycles on the first beat → stall_cnt=5.
